// File: rtl/iter_mag_comp_pkg.sv
// Shared types and derived sizes for the chunked magnitude comparator.
package iter_mag_comp_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk compare still needs a 1-bit index register.
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/iter_mag_comp_if.sv
// Request/result bundle for iter_mag_comp; start is a level sampled only in IDLE or DONE.
interface iter_mag_comp_if
  import iter_mag_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  // start is accepted on any rising edge where the FSM sits in IDLE or DONE;
  // done is a one-cycle pulse and less/greater/equal hold until the next result.
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             less;
  logic             greater;
  logic             equal;
  state_e           dbg_state;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, less, greater, equal, dbg_state
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, less, greater, equal, dbg_state
  );

endinterface

// File: rtl/iter_mag_comp_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module iter_mag_comp_chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/iter_mag_comp.sv
// Multi-cycle magnitude comparator: scans CHUNK bits per clock from the MSB and
// stops at the first differing chunk; signed mode uses offset-binary on chunk 0.
module iter_mag_comp
  import iter_mag_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic               clk,
  input logic               rst,
  iter_mag_comp_if.slave    bus
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = calc_idx_w(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             less_q, less_d;
  logic             greater_q, greater_d;
  logic             equal_q, equal_d;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic             c_lt, c_gt, c_eq;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        chunk_b = b_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
    // Flipping both sign bits maps two's complement onto unsigned order.
    if (sgn_q && (idx_q == '0)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  iter_mag_comp_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (chunk_a),
    .b  (chunk_b),
    .lt (c_lt),
    .gt (c_gt),
    .eq (c_eq)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    less_d    = less_q;
    greater_d = greater_q;
    equal_d   = equal_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.signed_mode;
          idx_d   = '0;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!c_eq) begin
          less_d    = c_lt;
          greater_d = c_gt;
          equal_d   = 1'b0;
          state_d   = ST_DONE;
        end else if (idx_q == IDX_LAST) begin
          less_d    = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      less_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      less_q    <= less_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
    end
  end

  assign bus.busy      = (state_q == ST_SCAN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.less      = less_q;
  assign bus.greater   = greater_q;
  assign bus.equal     = equal_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_iter_mag_comp.sv
// Scoreboard bench for iter_mag_comp (WIDTH=16, CHUNK=4) with directed vectors.
module tb_iter_mag_comp;
  import iter_mag_comp_pkg::*;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int EW    = 11;  // {latency[7:0], less, greater, equal}

  logic clk;
  logic rst;
  iter_mag_comp_if #(.WIDTH(WIDTH)) bus ();

  iter_mag_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  int            st_q[$];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      logic [EW-1:0] e;
      int            st;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending compare (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        st = st_q.pop_front();
        if ({bus.less, bus.greater, bus.equal} !== e[2:0]) begin
          failures++;
          $display("FAIL result: got lge=%b expected lge=%b", {bus.less, bus.greater, bus.equal}, e[2:0]);
        end
        checks++;
        if ((cyc - st) != int'(e[10:3])) begin
          failures++;
          $display("FAIL latency: got %0d edges expected %0d", cyc - st, e[10:3]);
        end
      end
    end
  end

  // Driver: called just after a posedge; start is sampled on the next edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sg, input logic [2:0] lge, input int lat);
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sg;
    bus.start       = 1'b1;
    exp_q.push_back({8'(lat), lge});
    st_q.push_back(cyc);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected a done pulse", n);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    rst             = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus.busy, bus.done, bus.less, bus.greater, bus.equal}), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    idle_cycles(2);

    // lge = {less, greater, equal}
    issue(16'h1234, 16'h1234, 1'b0, 3'b001, 5); wait_done(); idle_cycles(2);
    issue(16'h8000, 16'h7FFF, 1'b0, 3'b010, 2); wait_done(); idle_cycles(2);
    issue(16'h8000, 16'h7FFF, 1'b1, 3'b100, 2); wait_done(); idle_cycles(2);
    issue(16'h00F1, 16'h00F2, 1'b0, 3'b100, 5); wait_done(); idle_cycles(2);
    issue(16'h7FFF, 16'h8000, 1'b1, 3'b010, 2); wait_done(); idle_cycles(2);
    issue(16'h0100, 16'h0200, 1'b0, 3'b100, 3); wait_done(); idle_cycles(2);
    issue(16'h1230, 16'h1234, 1'b1, 3'b100, 5); wait_done(); idle_cycles(2);

    // Back-to-back: start held while DONE
    issue(16'hFFFE, 16'hFFFF, 1'b1, 3'b100, 5);
    wait_done();
    issue(16'h0005, 16'h0003, 1'b1, 3'b010, 5);
    wait_done();
    idle_cycles(2);

    // Start during SCAN must be ignored
    issue(16'h0000, 16'h0000, 1'b0, 3'b001, 5);
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.start = 1'b1;
    idle_cycles(1);
    bus.start = 1'b0;
    wait_done();
    idle_cycles(8);

    // Asynchronous reset in the middle of a scan
    issue(16'h0000, 16'h0001, 1'b0, 3'b100, 5);
    idle_cycles(1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    st_q.delete();
    #1;
    check("rst_mid_scan_outputs", 32'({bus.busy, bus.done, bus.less, bus.greater, bus.equal}), 32'd0);
    check("rst_mid_scan_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(10);
    check("post_rst_outputs", 32'({bus.busy, bus.done, bus.less, bus.greater, bus.equal}), 32'd0);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_mag_comp.md
Name: iter_mag_comp

Overview:
- Parametrised, multi-cycle magnitude comparator.
- Compares two WIDTH-bit operands CHUNK bits per clock, starting from the MSB, and exits early at the first differing chunk.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Successor to the 4-bit combinational comparator; used wherever wide compares must not sit on one combinational path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a compare; sampled only when state is IDLE or DONE
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with the operands
- a  input  WIDTH  operand A; latched on start acceptance
- b  input  WIDTH  operand B; latched on start acceptance
- busy  output  1  high while state is SCAN
- done  output  1  one-cycle pulse when a result is valid
- less  output  1  A < B (registered)
- greater  output  1  A > B (registered)
- equal  output  1  A == B (registered)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, less=0, greater=0, equal=0; internal operand registers and chunk index cleared.
- Constant: NCHUNK = WIDTH/CHUNK.
- FSM states are IDLE, SCAN and DONE.
- IDLE: start=1 latches a, b, signed_mode, sets idx=0 and moves to SCAN. start=0 stays in IDLE.
- SCAN: each clock compares chunk idx, i.e. bits [WIDTH-1-idx*CHUNK -: CHUNK] of the latched operands.
  - Chunks differ: set less/greater from the chunk compare, equal=0, go to DONE.
  - Chunks equal and idx==NCHUNK-1: equal=1, less=0, greater=0, go to DONE.
  - Otherwise: idx <= idx+1 and stay in SCAN.
- Signed mode: invert the MSB of both operands in chunk 0 only (offset-binary mapping); all remaining chunks compare unsigned.
- DONE: done=1 for exactly this cycle, busy=0.
  - start=1 here is accepted and the FSM goes straight to SCAN (back-to-back operation).
  - Otherwise the FSM goes to IDLE.
- Latency: if chunk k is the first differing chunk (k=NCHUNK-1 when the operands are equal), done is high k+2 clock edges after the start edge. Minimum 2 edges, maximum NCHUNK+1.
- Result outputs (less/greater/equal) update only on the edge that enters DONE and hold until the next result. Exactly one of the three is 1 after the first completed compare.
- start during SCAN is ignored, and a/b/signed_mode changes during SCAN have no effect.
- Asserting rst mid-SCAN aborts immediately: no done pulse, and results return to 0.
- CHUNK==WIDTH degenerates to NCHUNK=1: every compare has fixed 2-edge latency.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_SCAN=2'd1, ST_DONE=2'd2;
  - the NCHUNK derivation;
  - the index width, clog2(NCHUNK) with a minimum of 1.
- One natural sub-module, chunk_cmp: a combinational CHUNK-bit unsigned compare producing lt/gt/eq. Instantiated once; the top handles MSB inversion, slicing, the FSM and the result registers.

Test Plan (WIDTH=16, CHUNK=4):
- Unsigned a=16'h1234, b=16'h1234 -> busy for 4 cycles; done pulses 5 edges after start; equal=1, less=0, greater=0.
- a=16'h8000, b=16'h7FFF, unsigned -> done after 2 edges, greater=1. Repeat with signed_mode=1 -> done after 2 edges, less=1.
- Unsigned a=16'h00F1, b=16'h00F2 -> first difference at chunk 3; done after 5 edges; less=1.
- Signed a=16'hFFFE (-2), b=16'hFFFF (-1) -> less=1; then start held during DONE with a=5, b=3 -> back-to-back scan, no IDLE cycle; greater=1.
- start pulsed with a=1, b=2 mid-scan of a=16'h0000, b=16'h0000 -> second start ignored; result equal=1 with a single done pulse.
- rst asserted asynchronously during SCAN -> busy, done and results drop to 0 within the same cycle; no done pulse after rst releases until a new start.
